// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the VGA adapter pixel-write port among four draw
// engines (0 clear, 1 left paddle, 2 right paddle, 3 ball). Round-robin grant
// held for a whole burst; all outputs registered.
module vga_plot_arbiter #(
  parameter int MAX_BURST = 19200,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int C_W       = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0]       plot,
  input  logic [3:0]       last,
  input  logic [4*X_W-1:0] x_in,
  input  logic [4*Y_W-1:0] y_in,
  input  logic [4*C_W-1:0] colour_in,
  output logic [3:0]       gnt,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [C_W-1:0]   vga_colour,
  output logic             vga_plot,
  output logic             busy,
  output logic             timeout
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;

  state_t           state;
  logic [1:0]       owner;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] beat;

  logic [1:0]       win;
  logic             win_valid;
  logic [1:0]       cand;

  logic             own_req;
  logic             own_plot;
  logic             own_last;
  logic [X_W-1:0]   own_x;
  logic [Y_W-1:0]   own_y;
  logic [C_W-1:0]   own_c;

  // Round-robin pick: first requester scanning ptr, ptr+1, ... mod 4
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!win_valid && req[cand]) begin
        win       = cand;
        win_valid = 1'b1;
      end
    end
  end

  // Owner's request, strobe and pixel slice; non-owners never reach the port
  always_comb begin
    own_req  = req[owner];
    own_plot = plot[owner];
    own_last = last[owner];
    own_x    = x_in[owner*X_W +: X_W];
    own_y    = y_in[owner*Y_W +: Y_W];
    own_c    = colour_in[owner*C_W +: C_W];
  end

  // Arbitration FSM with registered grant, pixel and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      ptr        <= '0;
      beat       <= '0;
      gnt        <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            state <= BURST;
            owner <= win;
            gnt   <= 4'b0001 << win;
            beat  <= '0;
            busy  <= 1'b1;
          end
        end
        BURST: begin
          if (own_plot) begin
            vga_plot   <= 1'b1;
            vga_x      <= own_x;
            vga_y      <= own_y;
            vga_colour <= own_c;
            beat       <= beat + 1'b1;
          end
          // Completion outranks timeout; a dropped req ends the burst after
          // any pixel presented in the same cycle has been taken.
          if (own_plot && own_last) begin
            state <= RELEASE;
            gnt   <= '0;
          end else if (own_plot && beat == BEAT_LAST) begin
            state   <= RELEASE;
            gnt     <= '0;
            timeout <= 1'b1;
          end else if (!own_req) begin
            state <= RELEASE;
            gnt   <= '0;
          end
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ptr   <= owner + 2'd1;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter, built with MAX_BURST=4 so the
// forced-release path is reachable in a handful of cycles.
module tb_vga_plot_arbiter;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  logic             clk;
  logic             reset;
  logic [3:0]       req;
  logic [3:0]       plot;
  logic [3:0]       last;
  logic [4*X_W-1:0] x_in;
  logic [4*Y_W-1:0] y_in;
  logic [4*C_W-1:0] colour_in;
  logic [3:0]       gnt;
  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [C_W-1:0]   vga_colour;
  logic             vga_plot;
  logic             busy;
  logic             timeout;

  int tests_run;
  int tests_failed;
  int pulses;

  vga_plot_arbiter #(
    .MAX_BURST(4),
    .X_W(X_W),
    .Y_W(Y_W),
    .C_W(C_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .plot(plot),
    .last(last),
    .x_in(x_in),
    .y_in(y_in),
    .colour_in(colour_in),
    .gnt(gnt),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .vga_colour(vga_colour),
    .vga_plot(vga_plot),
    .busy(busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int i, input logic [X_W-1:0] x,
                         input logic [Y_W-1:0] y, input logic [C_W-1:0] c);
    x_in[i*X_W +: X_W]      = x;
    y_in[i*Y_W +: Y_W]      = y;
    colour_in[i*C_W +: C_W] = c;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_owner [5];
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b0;
    req       = '0;
    plot      = '0;
    last      = '0;
    x_in      = '0;
    y_in      = '0;
    colour_in = '0;
    tick();
    tick();

    // Reset state
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_plot", 32'(vga_plot), 32'h0);
    chk("rst_x", 32'(vga_x), 32'h0);
    chk("rst_y", 32'(vga_y), 32'h0);
    chk("rst_c", 32'(vga_colour), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tmo", 32'(timeout), 32'h0);
    reset = 1'b1;
    tick();
    chk("idle_gnt", 32'(gnt), 32'h0);

    // 1: three-pixel burst from requester 1
    req = 4'b0010;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_noplot", 32'(vga_plot), 32'h0);
    plot = 4'b0010;
    set_pix(1, 8'd10, 7'd20, 3'd3);
    tick();
    chk("t1_p1", 32'(vga_plot), 32'h1);
    chk("t1_x1", 32'(vga_x), 32'd10);
    chk("t1_y1", 32'(vga_y), 32'd20);
    chk("t1_c1", 32'(vga_colour), 32'd3);
    set_pix(1, 8'd11, 7'd20, 3'd3);
    tick();
    chk("t1_p2", 32'(vga_plot), 32'h1);
    chk("t1_x2", 32'(vga_x), 32'd11);
    set_pix(1, 8'd12, 7'd20, 3'd3);
    last = 4'b0010;
    tick();
    chk("t1_p3", 32'(vga_plot), 32'h1);
    chk("t1_x3", 32'(vga_x), 32'd12);
    chk("t1_gnt_drop", 32'(gnt), 32'h0);
    chk("t1_busy_rel", 32'(busy), 32'h1);
    chk("t1_tmo", 32'(timeout), 32'h0);
    plot = '0;
    last = '0;
    req  = '0;
    tick();
    chk("t1_p_end", 32'(vga_plot), 32'h0);
    chk("t1_x_hold", 32'(vga_x), 32'd12);
    chk("t1_busy_fall", 32'(busy), 32'h0);

    // 2: all four requesting, single-pixel bursts, round-robin from 0
    do_reset();
    exp_owner[0] = 2'd0;
    exp_owner[1] = 2'd1;
    exp_owner[2] = 2'd2;
    exp_owner[3] = 2'd3;
    exp_owner[4] = 2'd0;
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      tick();
      chk($sformatf("t2_gnt%0d", b), 32'(gnt), 32'(4'b0001 << exp_owner[b]));
      set_pix(int'(exp_owner[b]), 8'(100 + b), 7'(b), 3'(b));
      plot = 4'b0001 << exp_owner[b];
      last = 4'b0001 << exp_owner[b];
      tick();
      chk($sformatf("t2_plot%0d", b), 32'(vga_plot), 32'h1);
      chk($sformatf("t2_x%0d", b), 32'(vga_x), 32'(100 + b));
      chk($sformatf("t2_rel%0d", b), 32'(gnt), 32'h0);
      plot = '0;
      last = '0;
      if (b == 4) req = '0;
      tick();
      chk($sformatf("t2_idle%0d", b), 32'(gnt), 32'h0);
    end

    // 3: owner 2; other requesters' strobes must never reach the port
    req = 4'b0100;
    tick();
    chk("t3_gnt", 32'(gnt), 32'h4);
    set_pix(0, 8'd1, 7'd1, 3'd1);
    set_pix(1, 8'd2, 7'd2, 3'd2);
    set_pix(2, 8'd30, 7'd40, 3'd5);
    set_pix(3, 8'd4, 7'd4, 3'd4);
    plot = 4'b1011;
    last = 4'b1011;
    tick();
    chk("t3_ignored_plot", 32'(vga_plot), 32'h0);
    chk("t3_ignored_x", 32'(vga_x), 32'd104);
    chk("t3_still_gnt", 32'(gnt), 32'h4);
    plot = 4'b1111;
    last = 4'b1011;
    tick();
    chk("t3_p1", 32'(vga_plot), 32'h1);
    chk("t3_x1", 32'(vga_x), 32'd30);
    chk("t3_y1", 32'(vga_y), 32'd40);
    chk("t3_c1", 32'(vga_colour), 32'd5);
    chk("t3_gnt_hold", 32'(gnt), 32'h4);
    set_pix(2, 8'd31, 7'd41, 3'd6);
    plot = 4'b0100;
    last = 4'b0100;
    tick();
    chk("t3_x2", 32'(vga_x), 32'd31);
    chk("t3_c2", 32'(vga_colour), 32'd6);
    chk("t3_gnt_drop", 32'(gnt), 32'h0);
    plot = '0;
    last = '0;
    req  = '0;
    tick();

    // 4: owner 3 exceeds MAX_BURST=4; forced release, then 0 is granted
    req  = 4'b1001;
    tick();
    chk("t4_gnt", 32'(gnt), 32'h8);
    pulses = 0;
    plot = 4'b1000;
    last = 4'b0000;
    for (int k = 1; k <= 6; k++) begin
      set_pix(3, 8'(50 + k), 7'd9, 3'd7);
      tick();
      if (vga_plot) pulses++;
      if (k <= 4) chk($sformatf("t4_x%0d", k), 32'(vga_x), 32'(50 + k));
      chk($sformatf("t4_tmo%0d", k), 32'(timeout), (k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("t4_gnt%0d", k), 32'(gnt),
          (k <= 3) ? 32'h8 : ((k == 6) ? 32'h1 : 32'h0));
    end
    chk("t4_pulses", 32'(pulses), 32'd4);
    chk("t4_x_hold", 32'(vga_x), 32'd54);
    plot = '0;
    req  = '0;
    tick();
    chk("t4_abort0", 32'(gnt), 32'h0);
    tick();

    // 5: owner 1 aborts after two pixels; ptr moves to 2
    req = 4'b0010;
    tick();
    chk("t5_gnt", 32'(gnt), 32'h2);
    plot = 4'b0010;
    set_pix(1, 8'd70, 7'd5, 3'd1);
    tick();
    chk("t5_x1", 32'(vga_x), 32'd70);
    set_pix(1, 8'd71, 7'd5, 3'd1);
    tick();
    chk("t5_p2", 32'(vga_plot), 32'h1);
    chk("t5_x2", 32'(vga_x), 32'd71);
    plot = '0;
    req  = '0;
    tick();
    chk("t5_rel_gnt", 32'(gnt), 32'h0);
    chk("t5_rel_plot", 32'(vga_plot), 32'h0);
    chk("t5_rel_tmo", 32'(timeout), 32'h0);
    chk("t5_rel_busy", 32'(busy), 32'h1);
    req = 4'b1101;
    tick();
    chk("t5_idle_tmo", 32'(timeout), 32'h0);
    chk("t5_idle_gnt", 32'(gnt), 32'h0);
    tick();
    chk("t5_next_gnt", 32'(gnt), 32'h4);

    // 6: asynchronous reset mid-burst of requester 2
    plot = 4'b0100;
    set_pix(2, 8'd90, 7'd9, 3'd2);
    tick();
    chk("t6_pre_plot", 32'(vga_plot), 32'h1);
    chk("t6_pre_gnt", 32'(gnt), 32'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(gnt), 32'h0);
    chk("t6_async_plot", 32'(vga_plot), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'h0);
    plot = '0;
    req  = 4'b1111;
    tick();
    chk("t6_held_gnt", 32'(gnt), 32'h0);
    reset = 1'b1;
    tick();
    chk("t6_first_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case the sequence stalls
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single VGA adapter pixel-write port among four pixel-drawing requesters: 0 = screen clear, 1 = left paddle, 2 = right paddle, 3 = ball.
- Grants the port for a whole burst, which ends on a last-flagged pixel, on requester abort, or on a burst-length timeout.
- Arbitration is round-robin; pixel outputs are registered.
- Sits between the per-object draw engines and the VGA adapter, replacing the fixed draw sequencing in the game FSM.

Parameters:
- MAX_BURST, 19200, maximum accepted pixels per grant (160x120 screen).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- C_W, 3, colour width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  4  per-requester request; held high for the whole burst.
- plot  in  4  per-requester pixel-valid strobe.
- last  in  4  per-requester final-pixel flag; qualified by plot.
- x_in  in  4*X_W  packed x coordinates; requester i at [i*X_W +: X_W].
- y_in  in  4*Y_W  packed y coordinates.
- colour_in  in  4*C_W  packed colours.
- gnt  out  4  one-hot grant; 0000 when the port is free.
- vga_x  out  X_W  registered pixel x.
- vga_y  out  Y_W  registered pixel y.
- vga_colour  out  C_W  registered pixel colour.
- vga_plot  out  1  registered write enable to the VGA adapter.
- busy  out  1  high while in BURST or RELEASE.
- timeout  out  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (asynchronous, active-low):
  - gnt=0, vga_x/vga_y/vga_colour=0, vga_plot=0, busy=0, timeout=0.
  - State=IDLE, rr pointer=0, beat counter=0.
  - Reset mid-burst drops gnt and vga_plot immediately; no pixel completes.
- States: IDLE, BURST, RELEASE; all outputs are registered.
- IDLE:
  - If req!=0, the winner is the first index i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
  - Next cycle: gnt=onehot(winner), state=BURST, beat counter=0.
  - If req=0, stay in IDLE.
- BURST, owner o:
  - Accepted pixel = plot[o] high in a cycle. On the next cycle vga_plot=1 with x/y/colour from slice o; beat counter +1.
  - Cycles with no accepted pixel give vga_plot=0 on the next cycle. The last vga_x/vga_y/vga_colour values are held.
  - plot/last from non-owners are ignored entirely.
  - Exit to RELEASE when any of these holds:
    - (a) plot[o]&last[o]: normal completion; that pixel is output.
    - (b) plot[o] with beat counter == MAX_BURST-1 and last[o]=0: forced release; that pixel is output; timeout=1 on the next cycle.
    - (c) req[o]=0 and plot[o]=0: abort; no pixel, no timeout.
  - req[o] dropping in the same cycle as plot[o]&last[o] is a normal completion (a).
  - req[o]=0 with plot[o]=1 and last[o]=0 counts as an accepted pixel followed by abort.
- RELEASE:
  - Lasts exactly one cycle with gnt=0 and busy=1.
  - ptr <= (o+1) mod 4 on all exit causes.
  - Next state is IDLE.
- Timing:
  - req in IDLE at cycle t gives gnt at t+1.
  - Burst end at t gives gnt=0 at t+1 and IDLE at t+2.
  - Earliest next grant is t+3.
  - Pixel latency is 1 cycle from plot to vga_plot.
- Counter width: ceil(log2(MAX_BURST+1)) bits; it never wraps because (b) fires first.
- Starvation: with all four requesting continuously, each requester is granted once every 4 bursts.

Test Plan:
1. Reset, then req=0010 and 3 plots from requester 1 at (10,20,c=3), (11,20,3), (12,20,3) with last on the 3rd -> gnt=0010 one cycle after req; three vga_plot pulses with matching values, each 1 cycle after its plot; gnt=0000 after the 3rd; busy falls 2 cycles after the last plot.
2. From reset, req=1111 held, each burst 1 pixel with last -> grant order 0,1,2,3,0; consecutive grants 3 cycles apart.
3. During a burst owned by 2, drive plot=1011 with distinct coordinates -> only requester 2's pixels appear on vga_*; the others are never output.
4. MAX_BURST=4, owner 3 plots 6 pixels with last=0 -> exactly 4 vga_plot pulses; timeout=1 for one cycle coinciding with the 4th pixel; gnt drops; next grant goes to 0 if requesting.
5. Owner 1 drops req after 2 pixels with no last -> release; 2 pixels output; timeout stays 0; ptr=2, so with req=1101 the next grant is 2.
6. Assert reset mid-burst of requester 2 -> gnt=0000 and vga_plot=0 without a clock edge; after reset release with req=1111 the first grant is 0.
